mac_dot_ctrl: RTL

Sequencer that drives the `mac_top` MAC unit as its initiator. It accepts a stream of signed operand pairs with an end-of-vector marker and buffers them in a small FIFO. For each pair it runs the MAC `start`/`ready_mac` handshake, clearing the accumulator at the start of every vector. It returns one dot-product result per vector over a valid/ready interface. It sits between the operand source and `mac_top`, and replaces the hand-driven stimulus sequence used at bench level.

---
 rtl/mac_pkg.sv | 24 ++
 rtl/mac_dot_ctrl_if.sv | 46 ++++
 rtl/mac_op_fifo.sv | 51 +++++
 rtl/mac_dot_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared MAC definitions: default widths, sequencer states
// and the operand-pair bundle carried through the FIFO.
package mac_pkg;

   localparam int MAC_DATA_W = 16;
   localparam int MAC_ACC_W  = 40;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ISSUE,
      ARM,
      WAIT,
      SETTLE,
      RESULT
   } mac_ctrl_state_e;

   typedef struct packed {
      logic                         last;
      logic signed [MAC_DATA_W-1:0] a;
      logic signed [MAC_DATA_W-1:0] b;
   } mac_op_t;

endpackage

// File: rtl/mac_dot_ctrl_if.sv
// Operand stream in, dot-product result stream out.
// master is the operand source / result sink side.
interface mac_dot_ctrl_if
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH = MAC_DATA_W,
   parameter int ACC_WIDTH  = MAC_ACC_W,
   parameter int CNT_WIDTH  = 8
) ();

   logic                         op_valid;
   logic                         op_ready;
   logic                         op_last;
   logic signed [DATA_WIDTH-1:0] op_a;
   logic signed [DATA_WIDTH-1:0] op_b;

   logic                         res_valid;
   logic                         res_ready;
   logic signed [ACC_WIDTH-1:0]  res_data;
   logic [CNT_WIDTH-1:0]         res_count;

   modport master (
      output op_valid,
      output op_last,
      output op_a,
      output op_b,
      input  op_ready,
      input  res_valid,
      input  res_data,
      input  res_count,
      output res_ready
   );

   modport slave (
      input  op_valid,
      input  op_last,
      input  op_a,
      input  op_b,
      output op_ready,
      output res_valid,
      output res_data,
      output res_count,
      input  res_ready
   );

endinterface

// File: rtl/mac_op_fifo.sv
// Synchronous operand FIFO; pointers carry a wrap bit so
// full and empty are told apart without a counter.
module mac_op_fifo
   import mac_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = mac_op_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  T     wdata,
   input  logic pop,
   output T     rdata,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   T           mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                  (wr_ptr[AW] != rd_ptr[AW]);

   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset; the pointers gate every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/mac_dot_ctrl.sv
// Dot-product sequencer: feeds buffered operand pairs to the
// MAC one at a time and returns one sum per vector.
module mac_dot_ctrl
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH = MAC_DATA_W,
   parameter int ACC_WIDTH  = MAC_ACC_W,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   mac_dot_ctrl_if.slave                io,
   output logic                         mac_start,
   output logic                         mac_clr_acc,
   output logic signed [DATA_WIDTH-1:0] mac_a,
   output logic signed [DATA_WIDTH-1:0] mac_b,
   input  logic                         mac_ready,
   input  logic signed [ACC_WIDTH-1:0]  mac_acc,
   output logic                         busy
);

   typedef struct packed {
      logic                         last;
      logic signed [DATA_WIDTH-1:0] a;
      logic signed [DATA_WIDTH-1:0] b;
   } op_t;

   op_t             wr_op;
   op_t             rd_op;
   logic            full;
   logic            empty;
   logic            pop;

   mac_ctrl_state_e state_q;
   mac_ctrl_state_e state_d;

   logic                        last_q;
   logic                        first_q;
   logic [CNT_WIDTH-1:0]        cnt_q;
   logic [CNT_WIDTH-1:0]        cnt_inc;
   logic signed [ACC_WIDTH-1:0] res_data_q;
   logic [CNT_WIDTH-1:0]        res_count_q;

   logic bump;
   logic capture;
   logic ack;

   assign wr_op = {io.op_last, io.op_a, io.op_b};

   mac_op_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (op_t)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (io.op_valid),
      .wdata (wr_op),
      .pop   (pop),
      .rdata (rd_op),
      .full  (full),
      .empty (empty)
   );

   assign io.op_ready  = !full;
   assign io.res_valid = (state_q == RESULT);
   assign io.res_data  = res_data_q;
   assign io.res_count = res_count_q;
   assign busy         = (state_q != IDLE) || !empty;

   // Pair counter sticks at all-ones instead of wrapping.
   assign cnt_inc = (&cnt_q) ? cnt_q
                             : cnt_q + CNT_WIDTH'(1);

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      mac_start   = 1'b0;
      mac_clr_acc = 1'b0;
      bump        = 1'b0;
      capture     = 1'b0;
      ack         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               if (first_q) begin
                  state_d = CLEAR;
               end else begin
                  state_d = ISSUE;
                  pop     = 1'b1;
               end
            end
         end
         CLEAR: begin
            mac_clr_acc = 1'b1;
            pop         = 1'b1;
            state_d     = ISSUE;
         end
         ISSUE: begin
            mac_start = 1'b1;
            state_d   = ARM;
         end
         // ready_mac may still show the previous op here.
         ARM: state_d = WAIT;
         WAIT: begin
            if (mac_ready) state_d = SETTLE;
         end
         SETTLE: begin
            bump = 1'b1;
            if (last_q) begin
               capture = 1'b1;
               state_d = RESULT;
            end else begin
               state_d = IDLE;
            end
         end
         RESULT: begin
            if (io.res_ready) begin
               ack     = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mac_a  <= '0;
         mac_b  <= '0;
         last_q <= 1'b0;
      end else if (pop) begin
         mac_a  <= rd_op.a;
         mac_b  <= rd_op.b;
         last_q <= rd_op.last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         first_q <= 1'b1;
      end else begin
         if (mac_clr_acc)  cnt_q <= '0;
         else if (bump)    cnt_q <= cnt_inc;
         if (ack)              first_q <= 1'b1;
         else if (mac_clr_acc) first_q <= 1'b0;
      end
   end

   // Accumulator is sampled in SETTLE, a cycle after ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_data_q  <= '0;
         res_count_q <= '0;
      end else if (capture) begin
         res_data_q  <= mac_acc;
         res_count_q <= cnt_inc;
      end
   end

endmodule
